board_io_ctrl: RTL and testbench

//  Parametrised board-IO front end between FPGA pins and the Ibex demo system.
//  - Synchronises and debounces NumIn raw button/switch inputs; emits one-cycle edge pulses.
//  - Drives NumLed LEDs from system GPO bits with per-LED PWM brightness and per-LED force-off masking.
//  - Instantiated in board tops in place of ad hoc per-pin LED/button logic.

---
 rtl/board_io_pkg.sv | 9 +
 rtl/io_debounce.sv | 57 +++++
 rtl/board_io_ctrl.sv | 53 +++++
 tb/tb_board_io_ctrl.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/board_io_pkg.sv
// board_io_pkg: shared widths, types and helpers for the board IO front end
package board_io_pkg;
  localparam int unsigned PwmWidth = 8;
  typedef logic [PwmWidth-1:0] pwm_duty_t;
  typedef enum logic {DbStable, DbCounting} db_state_e;
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/io_debounce.sv
// io_debounce: one input channel -- 2-flop synchroniser, stability counter, edge pulses
module io_debounce
  import board_io_pkg::*;
#(
  parameter int unsigned DebounceCycles = 50000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic db_o,
  output logic rise_o,
  output logic fall_o
);
  localparam int unsigned CntW = cnt_width(DebounceCycles);
  localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles - 1);
  logic meta_q, sync_q, db_q, db_d, rise_q, rise_d, fall_q, fall_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  db_state_e state;
  // synchroniser, stability counter and debounced level with its edge pulses
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      db_q   <= 1'b0;
      cnt_q  <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      meta_q <= raw_i;
      sync_q <= meta_q;
      db_q   <= db_d;
      cnt_q  <= cnt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end
  // count while the synchronised level disagrees; commit once it held for DebounceCycles
  always_comb begin
    state  = (sync_q != db_q) ? DbCounting : DbStable;
    db_d   = db_q;
    cnt_d  = '0;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (state == DbCounting) begin
      if (cnt_q == CntMax) begin
        db_d   = sync_q;
        rise_d = sync_q;
        fall_d = ~sync_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end
  assign db_o   = db_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;
endmodule

// File: rtl/board_io_ctrl.sv
// board_io_ctrl: debounced button/switch inputs and PWM-dimmed, maskable LED drive
module board_io_ctrl
  import board_io_pkg::*;
#(
  parameter int unsigned NumIn          = 8,
  parameter int unsigned NumLed         = 4,
  parameter int unsigned DebounceCycles = 50000,
  parameter int unsigned PwmWidth       = 8
) (
  input  logic                       clk_sys_i,
  input  logic                       rst_sys_ni,
  input  logic [NumIn-1:0]           in_raw_i,
  output logic [NumIn-1:0]           in_db_o,
  output logic [NumIn-1:0]           in_rise_o,
  output logic [NumIn-1:0]           in_fall_o,
  input  logic [NumLed-1:0]          led_val_i,
  input  logic [NumLed*PwmWidth-1:0] led_duty_i,
  input  logic [NumLed-1:0]          led_mask_i,
  output logic [NumLed-1:0]          led_o
);
  logic [PwmWidth-1:0] pwm_q;
  logic [NumLed-1:0]   pwm_on, led_d, led_q;
  for (genvar i = 0; i < NumIn; i++) begin : g_in
    io_debounce #(.DebounceCycles(DebounceCycles)) u_db (
      .clk_i (clk_sys_i),
      .rst_ni(rst_sys_ni),
      .raw_i (in_raw_i[i]),
      .db_o  (in_db_o[i]),
      .rise_o(in_rise_o[i]),
      .fall_o(in_fall_o[i])
    );
  end
  for (genvar i = 0; i < NumLed; i++) begin : g_led
    logic [PwmWidth-1:0] duty;
    assign duty      = led_duty_i[i*PwmWidth +: PwmWidth];
    assign pwm_on[i] = (&duty) | (pwm_q < duty);
  end
  // mask wins over enable and duty
  always_comb begin
    led_d = led_val_i & pwm_on & ~led_mask_i;
  end
  // free-running PWM counter and registered LED pins
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      pwm_q <= '0;
      led_q <= '0;
    end else begin
      pwm_q <= pwm_q + 1'b1;
      led_q <= led_d;
    end
  end
  assign led_o = led_q;
endmodule

// File: tb/tb_board_io_ctrl.sv
// tb_board_io_ctrl: table, directed and random checks of board_io_ctrl against a window-based model
module tb_board_io_ctrl;
  localparam int NI = 2, NL = 2, DC = 4, PW = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [NI-1:0] raw = '0, db, rise, fall;
  logic [NL-1:0] val = '0, mask = '0, led;
  logic [NL*PW-1:0] duty = '0;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;

  board_io_ctrl #(.NumIn(NI), .NumLed(NL), .DebounceCycles(DC), .PwmWidth(PW)) dut (
    .clk_sys_i(clk), .rst_sys_ni(rst_n), .in_raw_i(raw), .in_db_o(db), .in_rise_o(rise),
    .in_fall_o(fall), .led_val_i(val), .led_duty_i(duty), .led_mask_i(mask), .led_o(led)
  );

  // model: a level is accepted once the last DC synchronised samples all disagree with it
  bit [NI-1:0] m_s1, m_sync, m_db, m_rise, m_fall;
  bit m_hist[NI][$];
  int m_cnt;
  bit [NL-1:0] m_led;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0; m_sync = '0; m_db = '0; m_rise = '0; m_fall = '0; m_cnt = 0; m_led = '0;
    for (int c = 0; c < NI; c++) m_hist[c].delete();
  endtask

  task automatic model_edge();
    bit commit;
    int d;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int c = 0; c < NI; c++) begin
      m_hist[c].push_back(m_sync[c]);
      if (m_hist[c].size() > DC) void'(m_hist[c].pop_front());
      commit = (m_hist[c].size() == DC);
      for (int k = 0; k < m_hist[c].size(); k++) if (m_hist[c][k] == m_db[c]) commit = 0;
      m_rise[c] = commit && !m_db[c];
      m_fall[c] = commit && m_db[c];
      if (commit) m_db[c] = !m_db[c];
      m_sync[c] = m_s1[c];
      m_s1[c] = raw[c];
    end
    for (int l = 0; l < NL; l++) begin
      d = int'(duty[l*PW +: PW]);
      m_led[l] = val[l] && ((d == 2**PW - 1) || (m_cnt < d)) && !mask[l];
    end
    m_cnt = (m_cnt + 1) % (2**PW);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("db", 32'(db), 32'(m_db));
    check("rise", 32'(rise), 32'(m_rise));
    check("fall", 32'(fall), 32'(m_fall));
    check("led", 32'(led), 32'(m_led));
  endtask

  typedef struct {
    logic [NL-1:0] val, mask;
    logic [NL*PW-1:0] duty;
    int on0, on1;
  } led_vec_t;

  initial begin
    led_vec_t tbl[6];
    int n0, n1, cnt_a, cnt_b, at;
    tbl[0] = '{val: 2'b11, mask: 2'b00, duty: 8'hF4, on0: 4,  on1: 16};
    tbl[1] = '{val: 2'b11, mask: 2'b00, duty: 8'h00, on0: 0,  on1: 0};
    tbl[2] = '{val: 2'b01, mask: 2'b00, duty: 8'h0E, on0: 14, on1: 0};
    tbl[3] = '{val: 2'b11, mask: 2'b10, duty: 8'hF1, on0: 1,  on1: 0};
    tbl[4] = '{val: 2'b10, mask: 2'b00, duty: 8'h8F, on0: 0,  on1: 8};
    tbl[5] = '{val: 2'b11, mask: 2'b01, duty: 8'h3F, on0: 0,  on1: 3};
    model_reset();
    // reset held with toggling inputs
    val = 2'b11; duty = 8'hFF;
    for (int t = 0; t < 3; t++) begin
      raw = raw ^ 2'b11;
      tick();
      check("rst_outs", 32'({db, rise, fall, led}), 0);
    end
    rst_n = 1'b1; raw = 2'b01; val = '0; duty = '0;
    for (int t = 1; t <= 8; t++) begin
      tick();
      if (t == 5) check("rise_lat_db_before", 32'(db[0]), 0);
      if (t == 6) check("rise_lat_db", 32'(db[0]), 1);
      check("rise_lat_pulse", 32'(rise[0]), 32'(t == 6));
    end
    // glitch on channel 1 shorter than the debounce window
    raw[1] = 1'b1;
    repeat (3) tick();
    raw[1] = 1'b0;
    cnt_a = 0;
    for (int t = 0; t < 10; t++) begin
      tick();
      cnt_a += int'(db[1]) + int'(rise[1]) + int'(fall[1]);
    end
    check("glitch_reject", 32'(cnt_a), 0);
    // clean fall on channel 0
    raw[0] = 1'b0; cnt_a = 0; cnt_b = 0; at = 1;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (fall[0]) begin cnt_a++; at = int'(db[0]); end
      cnt_b += int'(rise[0]);
    end
    check("fall_count", 32'(cnt_a), 1);
    check("fall_coincident", 32'(at), 0);
    check("fall_no_rise", 32'(cnt_b), 0);
    // PWM table
    foreach (tbl[v]) begin
      val = tbl[v].val; mask = tbl[v].mask; duty = tbl[v].duty;
      tick();
      n0 = 0; n1 = 0;
      for (int t = 0; t < 16; t++) begin
        tick();
        n0 += int'(led[0]); n1 += int'(led[1]);
      end
      check($sformatf("pwm%0d_led0", v), 32'(n0), 32'(tbl[v].on0));
      check($sformatf("pwm%0d_led1", v), 32'(n1), 32'(tbl[v].on1));
    end
    // duty 0 then mask priority
    val = 2'b01; mask = '0; duty = 8'h00; n0 = 0;
    for (int t = 0; t < 16; t++) begin tick(); n0 += int'(led[0]); end
    check("duty0_off", 32'(n0), 0);
    duty = 8'h0F; tick();
    check("full_on", 32'(led[0]), 1);
    mask = 2'b01; tick();
    check("mask_on", 32'(led[0]), 0);
    mask = 2'b00; tick();
    check("mask_off", 32'(led[0]), 1);
    // async reset mid-count and mid-PWM
    duty = 8'h04; raw = 2'b10;
    repeat (4) tick();
    #2 rst_n = 1'b0;
    model_reset();
    #1 check("async_rst", 32'({db, rise, fall, led}), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      tick();
      check("rst_pwm_restart", 32'(led[0]), 32'(t <= 4));
      check("rst_db_restart", 32'(rise[1]), 32'(t == 6));
    end
    // random traffic against the model
    for (int t = 0; t < 600; t++) begin
      if ($urandom_range(0, 5) == 0) raw[$urandom_range(0, NI-1)] ^= 1'b1;
      if (t % 25 == 0) begin
        val = NL'($urandom); mask = NL'($urandom & $urandom); duty = (NL*PW)'($urandom);
      end
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
